// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Purpose : Shares one 16-bit memory port between instruction fetch (IF) and
//           data access (MEM). Decodes the virtual address into RAM
//           (0x0000-0x7FFF, word address = vaddr>>1), ROM (0xFF00-0xFFFF,
//           address {8'h00, vaddr[7:0]}) or unmapped, sequences the
//           multi-cycle SRAM strobes and returns read data to the granted
//           requester.
// Ports   : clk, rst (async, active high)
//           if_req/if_addr            -> if_ack/if_rdata
//           mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata
//           ram_addr/ram_din/ram_dout/ram_dout_oe/ram_ce_n/ram_oe_n/ram_we_n
//           rom_addr/rom_data (combinational ROM), busy
// Params  : RAM_WAIT - SRAM access length in cycles, 1..15
// Macro   : FAIR_ARB_EN - round-robin on simultaneous requests; when not
//           defined MEM always wins ties.
// Revision: 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int RAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic        mem_ack,
  output logic [15:0] mem_rdata,
  output logic [15:0] ram_addr,
  input  logic [15:0] ram_din,
  output logic [15:0] ram_dout,
  output logic        ram_dout_oe,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [15:0] rom_addr,
  input  logic [16-1:0] rom_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    ROM_RD  = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_we;
  logic        gnt_mem;   // requester owning the current transaction
  logic        last_mem;  // requester granted most recently (0 = IF)
  logic [15:0] rdata;

  logic        any_req;
  logic        pick_mem;
  logic [15:0] sel_addr;
  logic        sel_we;
  logic        sel_ram;
  logic        sel_rom;

  // Arbitration and decode of the requester that would be granted now.
  always_comb begin
`ifdef FAIR_ARB_EN
    pick_mem = mem_req && (!if_req || !last_mem);
`else
    pick_mem = mem_req;
`endif
    any_req  = if_req || mem_req;
    sel_addr = pick_mem ? mem_addr : if_addr;
    sel_we   = pick_mem && mem_we;
    sel_ram  = ~sel_addr[15];
    sel_rom  = &sel_addr[15:8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      lat_we    <= 1'b0;
      gnt_mem   <= 1'b0;
      last_mem  <= 1'b0;
      rdata     <= 16'h0000;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_addr  <= sel_addr;
            lat_we    <= sel_we;
            lat_wdata <= pick_mem ? mem_wdata : 16'h0000;
            gnt_mem   <= pick_mem;
            last_mem  <= pick_mem;
            wait_cnt  <= 4'(RAM_WAIT - 1);
            // Unmapped accesses go straight to ACK with zero data.
            if (!sel_ram && !sel_rom)
              rdata <= 16'h0000;
          end
        end
        RAM_ACC: begin
          if (wait_cnt == 4'd0)
            rdata <= lat_we ? 16'h0000 : ram_din;
          else
            wait_cnt <= wait_cnt - 4'd1;
        end
        ROM_RD: rdata <= lat_we ? 16'h0000 : rom_data;
        default: ;
      endcase
    end
  end

  // Next state and strobes; strobes come straight from the state register so
  // an asynchronous reset releases them immediately.
  always_comb begin
    state_nxt   = state;
    ram_ce_n    = 1'b1;
    ram_oe_n    = 1'b1;
    ram_we_n    = 1'b1;
    ram_dout_oe = 1'b0;
    if_ack      = 1'b0;
    mem_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (sel_ram)      state_nxt = RAM_ACC;
          else if (sel_rom) state_nxt = ROM_RD;
          else              state_nxt = ACK;
        end
      end
      RAM_ACC: begin
        ram_ce_n    = 1'b0;
        ram_oe_n    = lat_we;
        ram_we_n    = ~lat_we;
        ram_dout_oe = lat_we;
        if (wait_cnt == 4'd0)
          state_nxt = ACK;
      end
      ROM_RD: state_nxt = ACK;
      ACK: begin
        if_ack    = ~gnt_mem;
        mem_ack   = gnt_mem;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign ram_addr  = {1'b0, lat_addr[15:1]};
  assign rom_addr  = {8'h00, lat_addr[7:0]};
  assign ram_dout  = lat_wdata;
  assign if_rdata  = rdata;
  assign mem_rdata = rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Purpose : Randomized self-checking bench for mem_bus_arbiter. A word-level
//           SRAM model and a combinational ROM sit on the device side; the
//           expected data, latency, strobe counts and grant order come from a
//           transaction-level reference model.
// Macro   : FAIR_ARB_EN - selects the expected tie-break order.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
  localparam int RAM_WAIT = 2;
`ifdef FAIR_ARB_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [15:0] if_addr, mem_addr, mem_wdata;
  logic        if_ack, mem_ack;
  logic [15:0] if_rdata, mem_rdata;
  logic [15:0] ram_addr, ram_din, ram_dout, rom_addr, rom_data;
  logic        ram_dout_oe, ram_ce_n, ram_oe_n, ram_we_n, busy;

  mem_bus_arbiter #(.RAM_WAIT(RAM_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_dout_oe(ram_dout_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit last_mem;   // reference: requester granted most recently (0 = IF)

  function automatic logic [15:0] pat(input int i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    return {a[7:0] ^ 8'hC3, ~a[7:0]};
  endfunction

  // Device-side SRAM; the fill strobe loads a known pattern.
  logic        fill;
  logic [15:0] sram [0:32767];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 32768; i++) sram[i] <= pat(i);
    end else if (!ram_ce_n && !ram_we_n && ram_dout_oe) begin
      sram[ram_addr[14:0]] <= ram_dout;
    end
  end
  assign ram_din  = sram[ram_addr[14:0]];
  assign rom_data = rom_fn(rom_addr);

  // Reference memory image, updated only by completed transactions.
  logic [15:0] ref_mem [0:32767];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int region(input logic [15:0] a);
    if (a < 16'h8000)  return 0;
    if (a >= 16'hFF00) return 1;
    return 2;
  endfunction

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    case (region(a))
      0:       return ref_mem[a[15:1]];
      1:       return rom_fn({8'h00, a[7:0]});
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rand_addr(input int kind);
    case (kind)
      0:       return 16'($urandom_range(0, 16'h7FFF));
      1:       return 16'hFF00 | 16'($urandom_range(0, 255));
      default: return 16'($urandom_range(16'h8000, 16'hFEFF));
    endcase
  endfunction

  // Single transaction from an otherwise idle arbiter; called at a negedge.
  task automatic run_txn(input bit is_mem, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata);
    int r, exp_lat, cyc, ce_cnt, oe_cnt, we_cnt, oe_drv_cnt;
    bit got;
    logic [15:0] exp_d;
    r       = region(addr);
    exp_lat = (r == 0) ? RAM_WAIT + 1 : (r == 1) ? 2 : 1;
    exp_d   = we ? 16'h0000 : exp_read(addr);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    cyc = 0; got = 1'b0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; oe_drv_cnt = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!ram_ce_n) begin
        ce_cnt++;
        check("ram_addr", ram_addr, {1'b0, addr[15:1]});
      end
      if (!ram_oe_n) oe_cnt++;
      if (ram_dout_oe) oe_drv_cnt++;
      if (!ram_we_n) begin
        we_cnt++;
        check("ram_dout", ram_dout, wdata);
      end
      if (r == 1 && cyc == 1) check("rom_addr", rom_addr, {8'h00, addr[7:0]});
      check("other_ack", is_mem ? if_ack : mem_ack, 1'b0);
      got = is_mem ? mem_ack : if_ack;
    end
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    check("ack_seen", got, 1'b1);
    check("latency", cyc, exp_lat);
    check("ce_cycles", ce_cnt, (r == 0) ? RAM_WAIT : 0);
    check("oe_cycles", oe_cnt, (r == 0 && !we) ? RAM_WAIT : 0);
    check("we_cycles", we_cnt, (r == 0 && we) ? RAM_WAIT : 0);
    check("doe_cycles", oe_drv_cnt, (r == 0 && we) ? RAM_WAIT : 0);
    if (!(r == 0 && we)) check("rdata", is_mem ? mem_rdata : if_rdata, exp_d);
    if (r == 0 && we) ref_mem[addr[15:1]] = wdata;
    last_mem = is_mem;
    @(negedge clk);
    check("ack_pulse", {if_ack, mem_ack, busy}, 3'b000);
  endtask

  // Both requesters issue reads together; each needs k acks and holds req.
  task automatic run_tie(input logic [15:0] ia, input logic [15:0] ma,
                         input int k);
    int left_if, left_mem, cyc;
    bit exp_mem, got_mem, stop;
    left_if = k; left_mem = k; stop = 1'b0;
    if_req = 1'b1; if_addr = ia;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = ma;
    while ((left_if + left_mem) > 0 && !stop) begin
      if (left_if > 0 && left_mem > 0) exp_mem = FAIR ? !last_mem : 1'b1;
      else                             exp_mem = (left_mem > 0);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!if_ack && !mem_ack && cyc < 40);
      if (!if_ack && !mem_ack) begin
        check("tie_timeout", 1'b0, 1'b1);
        stop = 1'b1;
      end else begin
        got_mem = mem_ack;
        check("tie_onehot", {if_ack, mem_ack}, got_mem ? 2'b01 : 2'b10);
        check("tie_order", got_mem, exp_mem);
        check("tie_rdata", got_mem ? mem_rdata : if_rdata,
              exp_read(got_mem ? ma : ia));
        last_mem = got_mem;
        if (got_mem && left_mem > 0) left_mem--;
        if (!got_mem && left_if > 0) left_if--;
        if (left_mem == 0) mem_req = 1'b0;
        if (left_if == 0)  if_req = 1'b0;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    bit sp;
    rst = 1'b1; fill = 1'b1;
    if_req = 1'b0; if_addr = 16'h0000;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000;
    for (int i = 0; i < 32768; i++) ref_mem[i] = pat(i);
    last_mem = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fill = 1'b0;
    check("rst_acks_busy", {if_ack, mem_ack, busy, ram_dout_oe}, 4'b0000);
    check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
    check("rst_addrs", {ram_addr, rom_addr}, 32'h0);
    check("rst_data", {ram_dout, if_rdata}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the block description.
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000);
    run_txn(1'b1, 1'b1, 16'h0004, 16'hBEEF);
    run_txn(1'b1, 1'b0, 16'h0004, 16'h0000);
    run_txn(1'b0, 1'b0, 16'hFF12, 16'h0000);
    run_txn(1'b1, 1'b0, 16'h9000, 16'h0000);
    run_txn(1'b1, 1'b1, 16'hFF40, 16'h1234);
    run_txn(1'b1, 1'b1, 16'h8000, 16'h5678);
    run_txn(1'b0, 1'b0, 16'h7FFF, 16'h0000);
    run_tie(16'hFF20, 16'h0102, 1);
    run_tie(16'h0200, 16'hFF33, 2);

    // Reset in the middle of a RAM access.
    if_req = 1'b1; if_addr = 16'h0100;
    @(negedge clk);
    check("mid_ce_active", ram_ce_n, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_release", {ram_ce_n, ram_oe_n, ram_we_n, busy}, 4'b1110);
    @(negedge clk);
    if_req = 1'b0; rst = 1'b0;
    last_mem = 1'b0;
    sp = 1'b0;
    for (cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (if_ack || mem_ack) sp = 1'b1;
    end
    check("no_ack_after_rst", sp, 1'b0);
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000);

    // Randomized traffic.
    repeat (60) begin
      bit is_mem, we;
      int kind;
      is_mem = 1'($urandom_range(0, 1));
      kind   = $urandom_range(0, 2);
      we     = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($urandom_range(0, 2) == 0) run_txn(is_mem, we, 16'h0002, 16'($urandom));
      else run_txn(is_mem, we, rand_addr(kind), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (6) begin
      run_tie(rand_addr($urandom_range(0, 2)), rand_addr($urandom_range(0, 2)),
              $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
